mips_main_ctrl: RTL and testbench
=================================

Name: mips_main_ctrl

Overview:
Multicycle MIPS main control FSM. It sits directly upstream of the datapath enable-flops (PC, IR, register-file write, memory write) and drives their enables and the mux selects. It steps each instruction through fetch/decode/execute/memory/writeback, and stalls on memory via a ready handshake. It is a Moore machine: outputs decode from the state register only, apart from the ready and reset gating defined below.

Parameters:
STATE_W, 4, width of state register and of debug state output.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset); forces state to FETCH immediately
op  input  6  instruction opcode field (IR[31:26])
mem_ready  input  1  memory access completes this cycle
pcwrite  output  1  unconditional PC enable
branch  output  1  conditional PC enable (datapath ANDs with zero)
irwrite  output  1  IR enable
regwrite  output  1  register-file write enable
memwrite  output  1  data-memory write enable
iord  output  1  0 = PC addresses memory, 1 = ALUOut addresses memory
memtoreg  output  1  0 = ALUOut to register file, 1 = MDR to register file
regdst  output  1  0 = rt, 1 = rd destination
alusrca  output  1  0 = PC, 1 = A
alusrcb  output  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = imm<<2
aluop  output  2  00 add, 01 sub, 10 funct-decoded
pcsrc  output  2  00 ALU result, 01 ALUOut, 10 jump target
illegal  output  1  unsupported opcode seen in DECODE
state  output  STATE_W  current state (debug)

Behaviour:
- States and codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEXEC 9, ADDIWB 10, JUMP 11. Codes 12-15 go to FETCH next cycle with all outputs 0.
- Opcodes: R 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000, J 000010.
- Transitions:
  - FETCH -> DECODE when mem_ready; otherwise hold.
  - DECODE: LW/SW -> MEMADR, R -> EXECUTE, BEQ -> BRANCH, ADDI -> ADDIEXEC, J -> JUMP, any other op -> FETCH.
  - MEMADR: LW -> MEMRD, SW -> MEMWR. op is re-sampled here; IR is stable.
  - MEMRD -> MEMWB when mem_ready; otherwise hold.
  - MEMWR -> FETCH when mem_ready; otherwise hold.
  - EXECUTE -> ALUWB; ADDIEXEC -> ADDIWB.
  - MEMWB, ALUWB, ADDIWB, BRANCH, JUMP -> FETCH.
- Outputs per state; every output not listed is 0:
  - FETCH: alusrcb=01, irwrite=pcwrite=mem_ready.
  - DECODE: alusrcb=11; illegal=1 if op is unsupported.
  - MEMADR: alusrca=1, alusrcb=10.
  - MEMRD: iord=1.
  - MEMWB: memtoreg=1, regwrite=1.
  - MEMWR: iord=1, memwrite=mem_ready.
  - EXECUTE: alusrca=1, aluop=10.
  - ALUWB: regdst=1, regwrite=1.
  - BRANCH: alusrca=1, aluop=01, pcsrc=01, branch=1.
  - ADDIEXEC: alusrca=1, alusrcb=10.
  - ADDIWB: regwrite=1.
  - JUMP: pcsrc=10, pcwrite=1.
- Reset:
  - While reset=0, state=FETCH.
  - pcwrite, irwrite, regwrite, memwrite, branch and illegal are forced 0 combinationally, so all outputs read 0 apart from the FETCH mux selects (alusrcb=01).
  - Reset asserted mid-instruction aborts it: no partial write occurs after the asserting edge.
  - After release, the first rising edge evaluates FETCH normally.
- Latency: lw 5 cycles, sw 4, R 4, addi 4, beq 3, j 3. Each mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds one.
- A state-register update is exactly one clock; there is no output register.

Decomposition:
- Package mips_ctrl_pkg holds: state codes, opcode constants, aluop codes, alusrcb codes, pcsrc codes.
- One natural sub-module, mips_ctrl_outdec: purely combinational state -> control-word decoder, with mem_ready and reset gating applied in the parent.

Test Plan:
1. reset=0 for 3 cycles with op=LW and mem_ready=1 -> state=0; pcwrite=irwrite=regwrite=memwrite=0. Release reset -> next edge state=1.
2. op=100011, mem_ready=1 -> state sequence 0,1,2,3,4,0. regwrite=1 and memtoreg=1 only in state 4.
3. op=101011 with mem_ready=0 for 2 cycles in MEMWR -> state 5 held 3 cycles; memwrite=1 only in the ready cycle; then state 0.
4. op=000100 -> 0,1,8,0 with branch=1, pcsrc=01, aluop=01 in state 8. op=000010 -> 0,1,11,0 with pcwrite=1, pcsrc=10.
5. op=111111 -> DECODE asserts illegal=1 for one cycle, then state=0. No regwrite or memwrite pulse.
6. op=000000; drop reset to 0 asynchronously while in EXECUTE -> state=0 immediately, before the next edge; regwrite never asserts.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main controller: state codes,
// opcodes, ALU/mux select codes and the raw control word the decoder produces.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // memgate marks states whose enables only fire on the cycle memory is ready
  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       irwrite;
    logic       regwrite;
    logic       memwrite;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       illegal;
    logic       memgate;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  function automatic logic opSupported(input logic [5:0] opIn);
    return (opIn == OP_R) || (opIn == OP_LW) || (opIn == OP_SW) ||
           (opIn == OP_BEQ) || (opIn == OP_ADDI) || (opIn == OP_J);
  endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational state -> control-word decoder; ready and reset gating are
// left to the parent so this stays a pure Moore lookup.
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  logic [3:0]        state_i,
  input  logic [5:0]        op_i,
  output logic [CTRL_W-1:0] ctrl_o
);

  ctrl_t ctrl;

  always_comb begin
    ctrl = '0;
    case (state_i)
      S_FETCH: begin
        ctrl.alusrcb = SRCB_FOUR;
        ctrl.pcwrite = 1'b1;
        ctrl.irwrite = 1'b1;
        ctrl.memgate = 1'b1;
      end
      S_DECODE: begin
        ctrl.alusrcb = SRCB_IMMSH;
        ctrl.illegal = ~opSupported(op_i);
      end
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.iord    = 1'b1;
        ctrl.memgate = 1'b1;
      end
      S_MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
        ctrl.memgate  = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_SUB;
        ctrl.pcsrc   = PCSRC_ALUOUT;
        ctrl.branch  = 1'b1;
      end
      S_ADDIEXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
      end
      S_ADDIWB: begin
        ctrl.regwrite = 1'b1;
      end
      S_JUMP: begin
        ctrl.pcsrc   = PCSRC_JUMP;
        ctrl.pcwrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign ctrl_o = ctrl;

endmodule

// File: rtl/mips_main_ctrl.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/
// writeback and drives datapath enables and mux selects from the state register.
module mips_main_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic               mem_ready,
  output logic               pcwrite,
  output logic               branch,
  output logic               irwrite,
  output logic               regwrite,
  output logic               memwrite,
  output logic               iord,
  output logic               memtoreg,
  output logic               regdst,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         aluop,
  output logic [1:0]         pcsrc,
  output logic               illegal,
  output logic [STATE_W-1:0] state
);

  state_e            state_q, state_d;
  logic [CTRL_W-1:0] ctrlVec;
  ctrl_t             ctrl;
  logic              memOk;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LW)      state_d = S_MEMRD;
        else if (op == OP_SW) state_d = S_MEMWR;
        else                  state_d = S_FETCH;
      end
      S_MEMRD:    if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:    if (mem_ready) state_d = S_FETCH;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ADDIEXEC: state_d = S_ADDIWB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  mips_ctrl_outdec u_outdec (
    .state_i (state_q),
    .op_i    (op),
    .ctrl_o  (ctrlVec)
  );

  assign ctrl  = ctrl_t'(ctrlVec);
  assign memOk = ~ctrl.memgate | mem_ready;

  // Enables are gated by reset so an asserted reset can never leak a write
  assign pcwrite  = ctrl.pcwrite  & memOk & reset;
  assign irwrite  = ctrl.irwrite  & memOk & reset;
  assign memwrite = ctrl.memwrite & memOk & reset;
  assign regwrite = ctrl.regwrite & reset;
  assign branch   = ctrl.branch   & reset;
  assign illegal  = ctrl.illegal  & reset;

  assign iord     = ctrl.iord;
  assign memtoreg = ctrl.memtoreg;
  assign regdst   = ctrl.regdst;
  assign alusrca  = ctrl.alusrca;
  assign alusrcb  = ctrl.alusrcb;
  assign aluop    = ctrl.aluop;
  assign pcsrc    = ctrl.pcsrc;
  assign state    = STATE_W'(state_q);

endmodule

// File: tb/tb_mips_main_ctrl.sv
// Directed scoreboard bench for mips_main_ctrl: expected state and control
// word are queued as each step is driven, then popped and checked.
module tb_mips_main_ctrl;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RTY  = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] BAD  = 6'b111111;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic       mem_ready;
  logic       pcwrite, branch, irwrite, regwrite, memwrite;
  logic       iord, memtoreg, regdst, alusrca, illegal;
  logic [1:0] alusrcb, aluop, pcsrc;
  logic [3:0] state;

  typedef struct {
    int          step;
    logic [3:0]  st;
    logic [15:0] word;
  } exp_t;

  exp_t scoreboard[$];
  int   testCount = 0;
  int   failCount = 0;
  int   stepNum   = 0;

  mips_main_ctrl #(.STATE_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .mem_ready (mem_ready),
    .pcwrite   (pcwrite),
    .branch    (branch),
    .irwrite   (irwrite),
    .regwrite  (regwrite),
    .memwrite  (memwrite),
    .iord      (iord),
    .memtoreg  (memtoreg),
    .regdst    (regdst),
    .alusrca   (alusrca),
    .alusrcb   (alusrcb),
    .aluop     (aluop),
    .pcsrc     (pcsrc),
    .illegal   (illegal),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference control word per state, written straight from the output table
  function automatic logic [15:0] expWord(input logic [3:0] s, input logic [5:0] o,
                                          input logic rdy, input logic rstN);
    logic       pcw, br, irw, rw, mw, io, m2r, rd, sa, ill;
    logic [1:0] sb, ao, ps;
    {pcw, br, irw, rw, mw, io, m2r, rd, sa, ill} = '0;
    sb = 2'b00; ao = 2'b00; ps = 2'b00;
    case (s)
      4'd0:  begin sb = 2'b01; pcw = rdy; irw = rdy; end
      4'd1:  begin
        sb  = 2'b11;
        ill = !(o == RTY || o == LW || o == SW || o == BEQ || o == ADDI || o == JMP);
      end
      4'd2:  begin sa = 1'b1; sb = 2'b10; end
      4'd3:  io = 1'b1;
      4'd4:  begin m2r = 1'b1; rw = 1'b1; end
      4'd5:  begin io = 1'b1; mw = rdy; end
      4'd6:  begin sa = 1'b1; ao = 2'b10; end
      4'd7:  begin rd = 1'b1; rw = 1'b1; end
      4'd8:  begin sa = 1'b1; ao = 2'b01; ps = 2'b01; br = 1'b1; end
      4'd9:  begin sa = 1'b1; sb = 2'b10; end
      4'd10: rw = 1'b1;
      4'd11: begin ps = 2'b10; pcw = 1'b1; end
      default: ;
    endcase
    if (!rstN) {pcw, irw, rw, mw, br, ill} = '0;
    return {pcw, br, irw, rw, mw, io, m2r, rd, sa, sb, ao, ps, ill};
  endfunction

  task automatic checkOutput();
    exp_t        e;
    logic [15:0] obs;
    e   = scoreboard.pop_front();
    obs = {pcwrite, branch, irwrite, regwrite, memwrite, iord, memtoreg, regdst,
           alusrca, alusrcb, aluop, pcsrc, illegal};
    testCount++;
    assert (state === e.st) else begin
      failCount++;
      $error("[TB] FAIL state step %0d: observed %0d expected %0d", e.step, state, e.st);
    end
    testCount++;
    assert (obs === e.word) else begin
      failCount++;
      $error("[TB] FAIL ctrlword step %0d (state %0d): observed %h expected %h",
             e.step, e.st, obs, e.word);
    end
  endtask

  task automatic pushExpect(input logic [3:0] expSt);
    exp_t e;
    stepNum++;
    e.step = stepNum;
    e.st   = expSt;
    e.word = expWord(expSt, op, mem_ready, reset);
    scoreboard.push_back(e);
  endtask

  task automatic applyStimulus(input logic rstV, input logic [5:0] opV,
                               input logic rdyV, input logic [3:0] expSt);
    @(negedge clk);
    reset     = rstV;
    op        = opV;
    mem_ready = rdyV;
    pushExpect(expSt);
    #1;
    checkOutput();
  endtask

  // Drops reset mid-cycle, well before the next rising edge
  task automatic applyAsyncReset();
    #2;
    reset = 1'b0;
    pushExpect(4'd0);
    #1;
    checkOutput();
  endtask

  initial begin
    reset     = 1'b1;
    op        = LW;
    mem_ready = 1'b1;
    #1 reset  = 1'b0;

    // Held in reset with a ready lw pending: only FETCH selects visible
    repeat (3) applyStimulus(1'b0, LW, 1'b1, 4'd0);

    // lw: release then 0,1,2,3,4,0
    applyStimulus(1'b1, LW, 1'b1, 4'd0);
    applyStimulus(1'b1, LW, 1'b1, 4'd1);
    applyStimulus(1'b1, LW, 1'b1, 4'd2);
    applyStimulus(1'b1, LW, 1'b1, 4'd3);
    applyStimulus(1'b1, LW, 1'b1, 4'd4);

    // sw with two stalled MEMWR cycles
    applyStimulus(1'b1, SW, 1'b1, 4'd0);
    applyStimulus(1'b1, SW, 1'b1, 4'd1);
    applyStimulus(1'b1, SW, 1'b1, 4'd2);
    applyStimulus(1'b1, SW, 1'b0, 4'd5);
    applyStimulus(1'b1, SW, 1'b0, 4'd5);
    applyStimulus(1'b1, SW, 1'b1, 4'd5);

    // beq with a stalled FETCH first
    applyStimulus(1'b1, BEQ, 1'b0, 4'd0);
    applyStimulus(1'b1, BEQ, 1'b1, 4'd0);
    applyStimulus(1'b1, BEQ, 1'b1, 4'd1);
    applyStimulus(1'b1, BEQ, 1'b1, 4'd8);

    // j
    applyStimulus(1'b1, JMP, 1'b1, 4'd0);
    applyStimulus(1'b1, JMP, 1'b1, 4'd1);
    applyStimulus(1'b1, JMP, 1'b1, 4'd11);

    // unsupported opcode
    applyStimulus(1'b1, BAD, 1'b1, 4'd0);
    applyStimulus(1'b1, BAD, 1'b1, 4'd1);

    // addi
    applyStimulus(1'b1, ADDI, 1'b1, 4'd0);
    applyStimulus(1'b1, ADDI, 1'b1, 4'd1);
    applyStimulus(1'b1, ADDI, 1'b1, 4'd9);
    applyStimulus(1'b1, ADDI, 1'b1, 4'd10);

    // R-type aborted by async reset inside EXECUTE
    applyStimulus(1'b1, RTY, 1'b1, 4'd0);
    applyStimulus(1'b1, RTY, 1'b1, 4'd1);
    applyStimulus(1'b1, RTY, 1'b1, 4'd6);
    applyAsyncReset();
    applyStimulus(1'b0, RTY, 1'b1, 4'd0);

    // lw after release with a stalled MEMRD
    applyStimulus(1'b1, LW, 1'b1, 4'd0);
    applyStimulus(1'b1, LW, 1'b1, 4'd1);
    applyStimulus(1'b1, LW, 1'b1, 4'd2);
    applyStimulus(1'b1, LW, 1'b0, 4'd3);
    applyStimulus(1'b1, LW, 1'b1, 4'd3);
    applyStimulus(1'b1, LW, 1'b1, 4'd4);
    applyStimulus(1'b1, LW, 1'b0, 4'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
